alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one clocked 4-bit ALU (OP1/OP2[3:0], OPCODE[2:0]) between NREQ requesters.
- Round-robin arbitration, per-requester valid/ready request ports, a single tagged response channel with backpressure.
- Sits between the requester blocks and the alu instance. It fully sequences each operation: accept, issue, wait for the fixed ALU latency, capture, respond.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ALU_LAT, 1, cycles from the ALU issue cycle to a valid alu_result (>=1).
- IDW, 2, width of the requester id, clog2(NREQ) (min 1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_op1  in  4*NREQ  packed operand 1; slice i belongs to requester i.
- req_op2  in  4*NREQ  packed operand 2.
- req_opcode  in  3*NREQ  packed opcode.
- alu_op1  out  4  operand 1 to ALU.
- alu_op2  out  4  operand 2 to ALU.
- alu_opcode  out  3  opcode to ALU.
- alu_valid  out  1  high for exactly the issue cycle.
- alu_result  in  4  ALU result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  requester index of the response.
- rsp_result  out  4  captured ALU result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, rr_ptr=0, wait counter=0.
  - All outputs 0: req_ready, alu_*, rsp_*, busy.
  - Reset mid-operation abandons the operation. No response is issued and the held data is discarded.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant g = first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - req_ready[g]=1 combinationally in the same cycle. The transfer happens at that edge: latch op1/op2/opcode slice g and g, then go to ISSUE.
  - No req_valid: stay in IDLE, req_ready=0.
- ISSUE (one cycle):
  - alu_op1/op2/opcode = latched values; alu_valid=1.
  - Load counter=ALU_LAT-1, go to WAIT.
- WAIT:
  - alu_* hold the latched values; alu_valid=0.
  - Counter 0: capture alu_result into rsp_result this edge, then go to RESP. Otherwise decrement.
  - With ALU_LAT=1 the capture happens at the end of the first WAIT cycle.
- RESP:
  - rsp_valid=1; rsp_id=g; rsp_result stable.
  - Handshake completes when rsp_valid & rsp_ready at an edge. Then rr_ptr = (g+1) mod NREQ and go to IDLE.
  - rsp_ready=0: hold indefinitely with all values stable.
- Latency and throughput:
  - Accept cycle t → alu_valid at t+1 → rsp_valid first high at t+ALU_LAT+2.
  - Minimum spacing between accepts is ALU_LAT+3 cycles.
  - Only one operation is in flight; req_ready=0 in every non-IDLE state.
- Requester rules: must hold req_valid and data stable until accepted. Deasserting before acceptance is legal and simply drops the request from arbitration.
- Simultaneous requests: exactly one grant per accept cycle. A requester is granted again only after every other requester that is continuously valid has been served.
- alu_* outputs keep their last values in IDLE/RESP (no toggling). They are 0 only after reset.
- Out-of-range opcodes are passed through unchanged; the arbiter never interprets OPCODE.

Test Plan:
- Bench ALU model: registered, opcode 3'b001 = OP1+OP2 mod 16, ALU_LAT=1, NREQ=4.
- Single request: req_valid=4'b0100, op1=3, op2=4, opc=001, rsp_ready=1 at cycle 0 → req_ready=4'b0100 at cycle 0, alu_valid cycle 1, rsp_valid cycle 3 with rsp_id=2, rsp_result=7, busy cycles 1..3.
- All four valid continuously from reset → grants in order 0,1,2,3,0, one accept every 4 cycles; rsp_id sequence 0,1,2,3,0.
- Requests on 0 and 3 with rr_ptr=1 (after serving id 0) → id 3 granted before id 0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises → rsp_valid/id/result stable, req_ready stays 0. Release → IDLE next cycle.
- Reset mid-op: assert rst during WAIT → next cycle state IDLE, rsp_valid never rises for that op, rr_ptr=0, all outputs 0.
- Wrap and carry: op1=15, op2=1, opc=001 from id 3 → rsp_result=0, rsp_id=3, next rr_ptr=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin front end that time-shares one clocked 4-bit ALU between NREQ requesters.
// One operation in flight: accept, issue, wait ALU_LAT cycles, capture, respond.
module alu_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int ALU_LAT = 1,
  parameter int IDW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_op1,
  input  logic [4*NREQ-1:0] req_op2,
  input  logic [3*NREQ-1:0] req_opcode,
  output logic [3:0]        alu_op1,
  output logic [3:0]        alu_op2,
  output logic [2:0]        alu_opcode,
  output logic              alu_valid,
  input  logic [3:0]        alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_result,
  output logic              busy
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [IDW-1:0]  gid_reg, gid_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [3:0]      op1_reg, op1_next;
  logic [3:0]      op2_reg, op2_next;
  logic [2:0]      opcode_reg, opcode_next;
  logic [3:0]      rsp_result_reg, rsp_result_next;

  logic [3:0]      op1_arr    [NREQ];
  logic [3:0]      op2_arr    [NREQ];
  logic [2:0]      opcode_arr [NREQ];

  logic            grant_found;
  logic [IDW-1:0]  grant_id;
  logic [NREQ-1:0] req_ready_c;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign op1_arr[gi]    = req_op1[4*gi +: 4];
      assign op2_arr[gi]    = req_op2[4*gi +: 4];
      assign opcode_arr[gi] = req_opcode[3*gi +: 3];
    end
  endgenerate

  // First valid requester at or after rr_ptr, wrapping past NREQ-1 back to 0.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    gid_next        = gid_reg;
    cnt_next        = cnt_reg;
    op1_next        = op1_reg;
    op2_next        = op2_reg;
    opcode_next     = opcode_reg;
    rsp_result_next = rsp_result_reg;
    req_ready_c     = '0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          req_ready_c = NREQ'(1) << grant_id;
          gid_next    = grant_id;
          op1_next    = op1_arr[grant_id];
          op2_next    = op2_arr[grant_id];
          opcode_next = opcode_arr[grant_id];
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = CW'(ALU_LAT - 1);
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          rsp_result_next = alu_result;
          state_next      = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rr_ptr_next = (gid_reg == IDW'(NREQ - 1)) ? '0 : gid_reg + 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      gid_reg        <= '0;
      cnt_reg        <= '0;
      op1_reg        <= '0;
      op2_reg        <= '0;
      opcode_reg     <= '0;
      rsp_result_reg <= '0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      gid_reg        <= gid_next;
      cnt_reg        <= cnt_next;
      op1_reg        <= op1_next;
      op2_reg        <= op2_next;
      opcode_reg     <= opcode_next;
      rsp_result_reg <= rsp_result_next;
    end
  end

  // Operand registers feed the ALU directly, so they hold their last values between operations.
  assign req_ready  = rst ? '0 : req_ready_c;
  assign alu_op1    = op1_reg;
  assign alu_op2    = op2_reg;
  assign alu_opcode = opcode_reg;
  assign alu_valid  = (state_reg == ISSUE);
  assign rsp_valid  = (state_reg == RESP);
  assign rsp_id     = gid_reg;
  assign rsp_result = rsp_result_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a registered one-cycle adder ALU model.
module tb_alu_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_op1;
  logic [4*NREQ-1:0] req_op2;
  logic [3*NREQ-1:0] req_opcode;
  logic [3:0]        alu_op1;
  logic [3:0]        alu_op2;
  logic [2:0]        alu_opcode;
  logic              alu_valid;
  logic [3:0]        alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_result;
  logic              busy;

  int total = 0;
  int bad   = 0;

  alu_share_arbiter #(.NREQ(NREQ), .ALU_LAT(1), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_opcode (req_opcode),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_opcode (alu_opcode),
    .alu_valid  (alu_valid),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU: opcode 001 adds mod 16, anything else yields 0.
  always_ff @(posedge clk)
    alu_result <= (alu_opcode == 3'b001) ? 4'(alu_op1 + alu_op2) : 4'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] hold_result;
    logic [IDW-1:0] hold_id;
    rst        = 1'b1;
    req_valid  = '0;
    req_op1    = '0;
    req_op2    = '0;
    req_opcode = '0;
    rsp_ready  = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_alu_valid", 32'(alu_valid), 0);
    chk("rst_alu_op1", 32'(alu_op1), 0);
    chk("rst_alu_opcode", 32'(alu_opcode), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    $display("txn reset done");

    // Single request from id 2: 3 + 4
    req_op1[11:8]    = 4'd3;
    req_op2[11:8]    = 4'd4;
    req_opcode[8:6]  = 3'b001;
    req_valid        = 4'b0100;
    #1;
    chk("single_ready_c0", 32'(req_ready), 32'h4);
    chk("single_busy_c0", 32'(busy), 0);
    tick();
    req_valid = '0;
    chk("single_alu_valid_c1", 32'(alu_valid), 1);
    chk("single_alu_op1_c1", 32'(alu_op1), 3);
    chk("single_alu_op2_c1", 32'(alu_op2), 4);
    chk("single_alu_opc_c1", 32'(alu_opcode), 1);
    chk("single_ready_c1", 32'(req_ready), 0);
    chk("single_busy_c1", 32'(busy), 1);
    tick();
    chk("single_alu_valid_c2", 32'(alu_valid), 0);
    chk("single_rsp_valid_c2", 32'(rsp_valid), 0);
    chk("single_busy_c2", 32'(busy), 1);
    tick();
    chk("single_rsp_valid_c3", 32'(rsp_valid), 1);
    chk("single_rsp_id_c3", 32'(rsp_id), 2);
    chk("single_rsp_result_c3", 32'(rsp_result), 7);
    chk("single_busy_c3", 32'(busy), 1);
    $display("txn single id=%0d result=%0d", rsp_id, rsp_result);
    tick();
    chk("single_rsp_valid_c4", 32'(rsp_valid), 0);
    chk("single_busy_c4", 32'(busy), 0);

    // All four valid continuously from reset: grants 0,1,2,3,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_op1[4*i +: 4]    = 4'(i);
      req_op2[4*i +: 4]    = 4'(i + 1);
      req_opcode[3*i +: 3] = 3'b001;
    end
    req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      int g;
      g = n % 4;
      chk("rr_grant", 32'(req_ready), 32'(1 << g));
      tick();
      if (n == 4) req_valid = '0;
      chk("rr_alu_valid", 32'(alu_valid), 1);
      chk("rr_alu_op1", 32'(alu_op1), 32'(g));
      tick();
      tick();
      chk("rr_rsp_valid", 32'(rsp_valid), 1);
      chk("rr_rsp_id", 32'(rsp_id), 32'(g));
      chk("rr_rsp_result", 32'(rsp_result), 32'(2 * g + 1));
      $display("txn rr n=%0d id=%0d result=%0d", n, rsp_id, rsp_result);
      tick();
    end
    chk("rr_idle_busy", 32'(busy), 0);

    // Requests on 0 and 3 with rr_ptr=1: id 3 first; 15+1 wraps to 0
    req_op1[15:12] = 4'd15;
    req_op2[15:12] = 4'd1;
    req_op1[3:0]   = 4'd5;
    req_op2[3:0]   = 4'd6;
    req_valid      = 4'b1001;
    #1;
    chk("prio_grant3", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0001;
    tick();
    tick();
    chk("wrap_rsp_valid", 32'(rsp_valid), 1);
    chk("wrap_rsp_id", 32'(rsp_id), 3);
    chk("wrap_rsp_result", 32'(rsp_result), 0);
    $display("txn wrap id=%0d result=%0d", rsp_id, rsp_result);
    tick();
    req_valid = 4'b1111;
    #1;
    chk("wrap_next_ptr0", 32'(req_ready), 32'h1);

    // Backpressure on id 0 response (5 + 6)
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("bp_rsp_valid", 32'(rsp_valid), 1);
    chk("bp_rsp_id", 32'(rsp_id), 0);
    chk("bp_rsp_result", 32'(rsp_result), 11);
    hold_id     = rsp_id;
    hold_result = rsp_result;
    req_valid   = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_valid", 32'(rsp_valid), 1);
      chk("bp_hold_id", 32'(rsp_id), 32'(hold_id));
      chk("bp_hold_result", 32'(rsp_result), 32'(hold_result));
      chk("bp_hold_ready", 32'(req_ready), 0);
      chk("bp_hold_busy", 32'(busy), 1);
    end
    $display("txn backpressure id=%0d result=%0d held", rsp_id, rsp_result);
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(rsp_valid), 0);
    chk("bp_release_busy", 32'(busy), 0);
    chk("bp_release_grant1", 32'(req_ready), 32'h2);
    req_valid = '0;
    #1;

    // Reset in WAIT abandons the operation
    req_op1[11:8] = 4'd9;
    req_op2[11:8] = 4'd9;
    req_valid     = 4'b0100;
    #1;
    chk("midrst_grant2", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick();
    chk("midrst_in_wait", 32'(busy), 1);
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_alu_op1", 32'(alu_op1), 0);
    chk("midrst_alu_op2", 32'(alu_op2), 0);
    chk("midrst_alu_valid", 32'(alu_valid), 0);
    chk("midrst_rsp_result", 32'(rsp_result), 0);
    chk("midrst_rsp_id", 32'(rsp_id), 0);
    rst       = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("midrst_ptr0", 32'(req_ready), 32'h1);
    req_valid = '0;
    #1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("midrst_no_rsp", 32'(rsp_valid), 0);
    end
    $display("txn midreset abandoned");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
